// File: rtl/display_controller.sv
// Display/keypad-entry controller: picks the display source and collects a BCD hh:mm entry.
// Optional ENTRY_VALIDATE_EN: only commit entries that are a valid 24 h time.
module display_controller #(
  parameter int unsigned TIMEOUT_S = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        tick_1hz,
  input  logic        show_alarm,
  input  logic        key_valid,
  input  logic [3:0]  key_value,
  output logic [1:0]  selector,
  output logic [15:0] keypad_time,
  output logic        load_time,
  output logic        load_alarm,
  output logic        entry_active
);

  typedef enum logic [1:0] {StIdle = 2'd0, StAlarm = 2'd1, StEntry = 2'd2} state_e;

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT_S);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d, cnt_inc;
  logic [15:0] keypad_d;
  logic        load_time_d, load_alarm_d;
  logic        is_digit, is_set_time, is_set_alarm, is_cancel, commit_ok;

  assign is_digit     = key_valid && (key_value <= 4'd9);
  assign is_set_time  = key_valid && (key_value == 4'hA);
  assign is_set_alarm = key_valid && (key_value == 4'hB);
  assign is_cancel    = key_valid && (key_value == 4'hC);
  assign cnt_inc      = cnt_q + 8'd1;

`ifdef ENTRY_VALIDATE_EN
  function automatic logic valid_time(input logic [15:0] t);
    logic digits_ok, hour_ok, min_ok;
    digits_ok = (t[15:12] <= 4'd9) && (t[11:8] <= 4'd9) && (t[7:4] <= 4'd9) && (t[3:0] <= 4'd9);
    hour_ok   = (t[15:12] <= 4'd1) || ((t[15:12] == 4'd2) && (t[11:8] <= 4'd3));
    min_ok    = (t[7:4] <= 4'd5);
    return digits_ok && hour_ok && min_ok;
  endfunction
  assign commit_ok = valid_time(keypad_time);
`else
  assign commit_ok = 1'b1;
`endif

  always_comb begin
    state_d      = state_q;
    keypad_d     = keypad_time;
    cnt_d        = cnt_q;
    load_time_d  = 1'b0;
    load_alarm_d = 1'b0;
    case (state_q)
      StIdle, StAlarm: begin
        // Clearing here also empties the buffer the cycle after a commit pulse.
        keypad_d = 16'h0000;
        cnt_d    = 8'd0;
        if (is_digit) begin
          state_d  = StEntry;
          keypad_d = {12'h000, key_value};
        end else begin
          state_d = show_alarm ? StAlarm : StIdle;
        end
      end
      StEntry: begin
        if (is_digit) begin
          keypad_d = {keypad_time[11:0], key_value};
          cnt_d    = 8'd0;
        end else if (is_set_time || is_set_alarm) begin
          cnt_d = 8'd0;
          if (commit_ok) begin
            state_d      = StIdle;
            load_time_d  = is_set_time;
            load_alarm_d = is_set_alarm;
          end
        end else if (is_cancel) begin
          state_d  = StIdle;
          keypad_d = 16'h0000;
          cnt_d    = 8'd0;
        end else if (tick_1hz) begin
          if (cnt_inc >= TimeoutCnt) begin
            state_d  = StIdle;
            keypad_d = 16'h0000;
            cnt_d    = 8'd0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: begin
        state_d  = StIdle;
        keypad_d = 16'h0000;
        cnt_d    = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      cnt_q        <= 8'd0;
      selector     <= 2'd0;
      keypad_time  <= 16'h0000;
      load_time    <= 1'b0;
      load_alarm   <= 1'b0;
      entry_active <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      selector     <= state_d;
      keypad_time  <= keypad_d;
      load_time    <= load_time_d;
      load_alarm   <= load_alarm_d;
      entry_active <= (state_d == StEntry);
    end
  end

endmodule

// File: doc/display_controller.md
DISPLAY_CONTROLLER -- requirements
Module: display_controller

Interface
REQ-001 SHALL have parameter TIMEOUT_S, default 10: number of tick_1hz pulses without a key press before an entry is aborted (range 1-255).
REQ-002 SHALL have ports: clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have ports: reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: tick_1hz  input  1  one-cycle pulse, once per second.
REQ-005 SHALL have ports: show_alarm  input  1  level input; high requests the alarm-time view.
REQ-006 SHALL have ports: key_valid  input  1  one-cycle pulse qualifying key_value.
REQ-007 SHALL have ports: key_value  input  4  key code: 0-9 digit, 0xA set-time, 0xB set-alarm, 0xC cancel, 0xD-0xF ignored.
REQ-008 SHALL have ports: selector  output  2  display mux select: 0 current, 1 alarm, 2 keypad.
REQ-009 SHALL have ports: keypad_time  output  16  entry buffer, BCD hh:mm, h[15:12] h[11:8] m[7:4] m[3:0].
REQ-010 SHALL have ports: load_time  output  1  one-cycle pulse: commit keypad_time to the current time.
REQ-011 SHALL have ports: load_alarm  output  1  one-cycle pulse: commit keypad_time to the alarm time.
REQ-012 SHALL have ports: entry_active  output  1  high while in ENTRY.

Function
REQ-013 SHALL implement a registered FSM with states IDLE (selector=0), ALARM_VIEW (selector=1) and ENTRY (selector=2); all outputs SHALL be registered.
REQ-014 IDLE->ALARM_VIEW when show_alarm=1; ALARM_VIEW->IDLE when show_alarm=0; selector SHALL follow one cycle after the input change.
REQ-015 In IDLE/ALARM_VIEW, a digit key SHALL enter ENTRY, with keypad_time = {12'h000, digit} on the next cycle.
REQ-016 In ENTRY, a digit key SHALL shift it in: keypad_time <= {keypad_time[11:0], digit}; a fifth or later digit discards the oldest digit.
REQ-017 In IDLE/ALARM_VIEW, non-digit keys SHALL be ignored; in every state, codes 0xD-0xF SHALL be ignored; show_alarm SHALL be ignored in ENTRY.
REQ-018 In ENTRY, set-time SHALL produce load_time=1 for exactly one cycle; keypad_time SHALL hold the entered value during that pulse; the state SHALL then be IDLE and keypad_time SHALL clear to 0 on the following cycle.
REQ-019 In ENTRY, set-alarm SHALL behave as REQ-018 but assert load_alarm; load_time and load_alarm SHALL never be high together.
REQ-020 In ENTRY, cancel SHALL return to IDLE and clear keypad_time, with no load pulse.
REQ-021 An 8-bit timeout counter SHALL reset to 0 on ENTRY entry and on each key press, and increment on tick_1hz in ENTRY; on reaching TIMEOUT_S it SHALL abort as in REQ-020.
REQ-022 If key_valid and tick_1hz coincide, the key SHALL win: the counter resets and no increment occurs.
REQ-023 A commit taken in the same cycle as a timeout SHALL win over the timeout.
REQ-024 Committing with fewer than 4 digits SHALL commit the buffer as is, zero-padded in the upper digits.

Reset
REQ-025 While reset_n=0: state=IDLE, selector=0, keypad_time=0, load_time=0, load_alarm=0, entry_active=0, timeout counter=0.
REQ-026 Reset asserted mid-entry SHALL abort immediately with no load pulse; the first key is accepted on the first clk edge after deassertion.

Configuration
REQ-027 With ENTRY_VALIDATE_EN defined, a commit SHALL proceed only if the buffer is a valid 24 h time (hh<=23, mm<=59, all digits BCD).
REQ-028 With ENTRY_VALIDATE_EN defined, an invalid commit SHALL produce no load pulse and SHALL stay in ENTRY with keypad_time unchanged and the timeout counter reset.
REQ-029 Without ENTRY_VALIDATE_EN, every commit SHALL proceed unconditionally.

Verification
REQ-030 Keys 1,2,3,4,A -> keypad_time=16'h1234 after the 4th digit; load_time pulses one cycle with 16'h1234; then selector=0 and keypad_time=0.
REQ-031 show_alarm 0->1->0 in IDLE -> selector 0->1->0, each change one cycle after the input.
REQ-032 Keys 5, then 10 tick_1hz pulses with TIMEOUT_S=10 -> return to IDLE with keypad_time=0 and no load pulses; key on the 10th tick cycle -> stays in ENTRY.
REQ-033 Keys 1,2,3,4,5,B -> load_alarm pulses with 16'h2345.
REQ-034 With ENTRY_VALIDATE_EN: keys 2,5,0,0,A -> no load_time and still in ENTRY; the same sequence without the macro -> load_time with 16'h2500.
REQ-035 reset_n pulsed low after keys 1,2 -> all outputs at reset values immediately, with no load pulse.
